exec_unit: RTL and testbench
============================

Name: exec_unit

Overview:
- Execute stage of the 8-bit CPU; sits directly upstream of the register file.
- Takes the register file's A and B read buses plus an opcode and destination.
- Computes the result and drives the register file write port (D, DA, w).
- Single-cycle ALU ops, plus a multi-cycle shift-add MUL; start/ready handshake with the control unit; registered status flags.

Parameters:
N, 8, datapath width; also the MUL iteration count.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets)
start  input  1  op request; accepted only when ready=1
op  input  4  opcode, sampled on accept
dest  input  3  destination register address, sampled on accept
A  input  N  operand A (register file A bus), sampled on accept
B  input  N  operand B (register file B bus), sampled on accept
ready  output  1  idle, can accept
done  output  1  one-cycle completion pulse, including illegal ops
w  output  1  register file write enable, one-cycle pulse
DA  output  3  write address to register file
D  output  N  write data to register file
Z N_f C V  output  1 each  zero, negative, carry/borrow, signed overflow

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, ready=1, done=0, w=0.
  - D=0, DA=0, all flags=0, MUL counter and accumulator cleared.
  - Takes effect immediately, including mid-MUL; the aborted op never writes.
- State machine: IDLE, MUL, DONE. ready = (state==IDLE).
  - IDLE, start=1: latch op/dest/A/B. op==MUL -> MUL; any other op -> DONE, with the result computed and registered on this same edge.
  - MUL: shift-add, one multiplier bit per cycle, counter 0..N-1. After N cycles -> DONE, D = low N bits of A*B.
  - DONE: done=1. w=1 for legal ops, w=0 for illegal ops. Next edge -> IDLE.
- start while ready=0 is ignored, with no side effects.
- Latency (start sampled at edge k):
  - Single-cycle op: done/w high during cycle k..k+1, ready again at k+2.
  - MUL: done/w high N+1 cycles after accept.
  - Throughput is one single-cycle op per 2 cycles.
- Opcodes. All results are truncated to N bits.
  - 0 ADD A+B
  - 1 SUB A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL A by 1 (zero fill)
  - 7 SHR A by 1 (logical)
  - 8 MOV A
  - 9 MUL (low byte)
  - 10 INC A
  - 11 DEC A
  - 12-15 illegal: D, DA and flags unchanged.
- Flags: updated on the edge entering DONE, legal ops only; they hold until the next legal completion.
  - Z = (result==0). N_f = result MSB.
  - C:
    - ADD/INC: carry out.
    - SUB/DEC: borrow, i.e. 1 when A < B unsigned (DEC: A==0).
    - SHL: shifted-out A[N-1]. SHR: shifted-out A[0].
    - MUL: 1 when the high N bits of the product are nonzero.
    - Otherwise 0.
  - V:
    - ADD/INC/SUB/DEC: two's-complement signed overflow.
    - Otherwise 0.
- D and DA hold their last written values between completions; w is the only qualifier.
- dest=7 is written normally (w=1). The register file discards the write because R7 is hardwired to zero; this block does not special-case it.
- Operands are latched at accept, so A/B/op/dest may change freely during MUL.

Test Plan:
- Reset: hold rst=0 mid-MUL (op=9, A=3, B=5, 4 cycles in), release -> ready=1, w never pulses, D=0, flags=0.
- ADD: A=8'hF0, B=8'h20, dest=2, start 1 cycle -> next cycle w=1, DA=2, D=8'h10, C=1, Z=0, V=0; ready=1 one cycle later.
- SUB: A=8'h05, B=8'h05 -> D=0, Z=1, C=0. Then A=8'h80, B=8'h01 -> D=8'h7F, V=1, C=0.
- MUL: A=8'd13, B=8'd21, dest=4 -> ready=0 for 9 cycles; w pulses exactly once at accept+9 with D=8'h11 (273 mod 256), C=1. Changing A/B during MUL has no effect.
- Illegal op=14 with flags Z=1 from a prior op -> done=1, w=0, D/DA/flags unchanged. A start asserted while ready=0 is ignored: no second pulse.
- SHL A=8'h81 -> D=8'h02, C=1. SHR A=8'h01 -> D=0, Z=1, C=1. Then dest=7, MOV A=8'h55 -> w=1, DA=7, D=8'h55.

Source files
------------

// File: rtl/exec_unit.sv
// Execute stage of the 8-bit CPU: single-cycle ALU ops plus an N-cycle shift-add MUL,
// driving the register file write port (D, DA, w) and registered status flags.
module exec_unit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [2:0]   dest,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         ready,
    output logic         done,
    output logic         w,
    output logic [2:0]   DA,
    output logic [N-1:0] D,
    output logic         Z,
    output logic         N_f,
    output logic         C,
    output logic         V
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_DEC = 4'd11;

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [1:0]     state;
    logic           legal_q;
    logic [2:0]     dest_q;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] acc_nxt;

    logic [N:0]     ext;
    logic [N-1:0]   alu_res;
    logic           alu_c;
    logic           alu_v;
    logic           alu_legal;

    // Single-cycle ops are evaluated straight off the operand buses so the
    // result lands on the accept edge.
    always_comb begin
        ext       = '0;
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_legal = 1'b1;
        case (op)
            OP_ADD: begin
                ext     = {1'b0, A} + {1'b0, B};
                alu_res = ext[N-1:0];
                alu_c   = ext[N];
                alu_v   = (A[N-1] == B[N-1]) && (alu_res[N-1] != A[N-1]);
            end
            OP_SUB: begin
                ext     = {1'b0, A} - {1'b0, B};
                alu_res = ext[N-1:0];
                alu_c   = ext[N];
                alu_v   = (A[N-1] != B[N-1]) && (alu_res[N-1] != A[N-1]);
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_NOT: alu_res = ~A;
            OP_SHL: begin
                alu_res = {A[N-2:0], 1'b0};
                alu_c   = A[N-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, A[N-1:1]};
                alu_c   = A[0];
            end
            OP_MOV: alu_res = A;
            OP_MUL: alu_res = '0;
            OP_INC: begin
                ext     = {1'b0, A} + (N+1)'(1);
                alu_res = ext[N-1:0];
                alu_c   = ext[N];
                alu_v   = ~A[N-1] & alu_res[N-1];
            end
            OP_DEC: begin
                ext     = {1'b0, A} - (N+1)'(1);
                alu_res = ext[N-1:0];
                alu_c   = ext[N];
                alu_v   = A[N-1] & ~alu_res[N-1];
            end
            default: alu_legal = 1'b0;
        endcase
    end

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            legal_q <= 1'b0;
            dest_q  <= '0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            D       <= '0;
            DA      <= '0;
            Z       <= 1'b0;
            N_f     <= 1'b0;
            C       <= 1'b0;
            V       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    dest_q <= dest;
                    if (op == OP_MUL) begin
                        state   <= S_MUL;
                        legal_q <= 1'b1;
                        acc     <= '0;
                        mcand   <= {{N{1'b0}}, A};
                        mplier  <= B;
                        cnt     <= '0;
                    end else begin
                        state   <= S_DONE;
                        legal_q <= alu_legal;
                        if (alu_legal) begin
                            D   <= alu_res;
                            DA  <= dest;
                            Z   <= (alu_res == '0);
                            N_f <= alu_res[N-1];
                            C   <= alu_c;
                            V   <= alu_v;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(N-1)) begin
                        state <= S_DONE;
                        D     <= acc_nxt[N-1:0];
                        DA    <= dest_q;
                        Z     <= (acc_nxt[N-1:0] == '0);
                        N_f   <= acc_nxt[N-1];
                        C     <= |acc_nxt[2*N-1:N];
                        V     <= 1'b0;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE);
    assign w     = done & legal_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed cases plus randomized ops against
// an arithmetic reference model of the register-file-visible behaviour.
module tb_exec_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] op;
    logic [2:0] dest;
    logic [7:0] A, B;
    logic       ready, done, w;
    logic [2:0] DA;
    logic [7:0] D;
    logic       Z, N_f, C, V;

    int n_chk  = 0;
    int n_fail = 0;

    // model of the architecturally visible state
    logic [7:0] m_d  = 8'h00;
    logic [2:0] m_da = 3'd0;
    logic [3:0] m_fl = 4'h0;

    exec_unit #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .dest(dest), .A(A), .B(B),
        .ready(ready), .done(done), .w(w), .DA(DA), .D(D),
        .Z(Z), .N_f(N_f), .C(C), .V(V)
    );

    always #5 clk = ~clk;

    // Observation layout: {latency, w pulses, busy cycles, D, DA, Z N C V}
    task automatic predict(input logic [3:0] o, input logic [2:0] dst,
                           input logic [7:0] a, input logic [7:0] b,
                           output logic [34:0] exp_v);
        int ua, ub, sa, sb, s, sr, lat;
        logic legal, c, v;
        logic [7:0] r;
        ua = a; ub = b;
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        s = 0; sr = 0; c = 1'b0; v = 1'b0; legal = 1'b1; lat = 1;
        case (o)
            4'd0:  begin s = ua + ub; sr = sa + sb; c = (s > 255); v = (sr > 127 || sr < -128); end
            4'd1:  begin s = ua - ub; sr = sa - sb; c = (ua < ub); v = (sr > 127 || sr < -128); end
            4'd2:  s = ua & ub;
            4'd3:  s = ua | ub;
            4'd4:  s = ua ^ ub;
            4'd5:  s = 255 - ua;
            4'd6:  begin s = ua * 2; c = (ua >= 128); end
            4'd7:  begin s = ua / 2; c = (ua % 2 == 1); end
            4'd8:  s = ua;
            4'd9:  begin s = ua * ub; c = (s > 255); lat = 9; end
            4'd10: begin s = ua + 1; sr = sa + 1; c = (s > 255); v = (sr > 127); end
            4'd11: begin s = ua - 1; sr = sa - 1; c = (ua == 0); v = (sr < -128); end
            default: legal = 1'b0;
        endcase
        r = s[7:0];
        if (legal) begin
            m_d  = r;
            m_da = dst;
            m_fl = {(r == 8'h00), r[7], c, v};
        end
        exp_v = {8'(lat), (legal ? 4'd1 : 4'd0), 8'(lat), m_d, m_da, m_fl};
    endtask

    // Issue one op from an idle negedge and watch it to completion; with
    // scramble set, inputs (and start) are thrashed while the unit is busy.
    task automatic run_op(input logic [3:0] o, input logic [2:0] dst,
                          input logic [7:0] a, input logic [7:0] b,
                          input bit scramble, output logic [34:0] obs);
        int lat, wcnt, busy;
        bit got;
        logic [7:0] d_s;
        logic [2:0] da_s;
        logic [3:0] fl_s;
        lat = 0; wcnt = 0; busy = 0; got = 1'b0;
        d_s = 'x; da_s = 'x; fl_s = 'x;
        op = o; dest = dst; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (!ready) busy++;
            if (done && !got) begin
                got = 1'b1; lat = i; d_s = D; da_s = DA; fl_s = {Z, N_f, C, V};
            end
            if (w) wcnt++;
            if (got && ready) begin
                start = 1'b0;
                break;
            end
            if (scramble) begin
                A = 8'($urandom); B = 8'($urandom); op = 4'($urandom);
                dest = 3'($urandom); start = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        obs = {8'(lat), 4'(wcnt), 8'(busy), d_s, da_s, fl_s};
    endtask

    task automatic test_reset();
        n_chk++;
        if ({ready, done, w, D, DA, Z, N_f, C, V} !== {1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", {ready, done, w, D, DA, Z, N_f, C, V},
                     {1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'h0});
        end
    endtask

    task automatic test_add();
        logic [34:0] e, o;
        predict(4'd0, 3'd2, 8'hF0, 8'h20, e);
        run_op(4'd0, 3'd2, 8'hF0, 8'h20, 1'b0, o);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL add_model: got %h want %h", o, e); end
        n_chk++;
        if (o !== {8'd1, 4'd1, 8'd1, 8'h10, 3'd2, 4'b0010}) begin
            n_fail++; $display("FAIL add_const: got %h want %h", o, {8'd1, 4'd1, 8'd1, 8'h10, 3'd2, 4'b0010});
        end
    endtask

    task automatic test_sub();
        logic [34:0] e, o;
        predict(4'd1, 3'd3, 8'h05, 8'h05, e);
        run_op(4'd1, 3'd3, 8'h05, 8'h05, 1'b0, o);
        n_chk++;
        if (o !== {8'd1, 4'd1, 8'd1, 8'h00, 3'd3, 4'b1000}) begin
            n_fail++; $display("FAIL sub_zero: got %h want %h", o, {8'd1, 4'd1, 8'd1, 8'h00, 3'd3, 4'b1000});
        end
        predict(4'd1, 3'd1, 8'h80, 8'h01, e);
        run_op(4'd1, 3'd1, 8'h80, 8'h01, 1'b0, o);
        n_chk++;
        if (o !== e || o[14:0] !== {8'h7F, 3'd1, 4'b0001}) begin
            n_fail++; $display("FAIL sub_ovf: got %h want %h", o, e);
        end
    endtask

    task automatic test_mul();
        logic [34:0] e, o;
        predict(4'd9, 3'd4, 8'd13, 8'd21, e);
        run_op(4'd9, 3'd4, 8'd13, 8'd21, 1'b1, o);
        n_chk++;
        if (o !== {8'd9, 4'd1, 8'd9, 8'h11, 3'd4, 4'b0010}) begin
            n_fail++; $display("FAIL mul_13x21: got %h want %h", o, {8'd9, 4'd1, 8'd9, 8'h11, 3'd4, 4'b0010});
        end
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL mul_model: got %h want %h", o, e); end
    endtask

    task automatic test_illegal();
        logic [34:0] e, o;
        predict(4'd1, 3'd3, 8'h05, 8'h05, e);
        run_op(4'd1, 3'd3, 8'h05, 8'h05, 1'b0, o);
        predict(4'd14, 3'd6, 8'hAA, 8'h55, e);
        run_op(4'd14, 3'd6, 8'hAA, 8'h55, 1'b1, o);
        n_chk++;
        if (o !== {8'd1, 4'd0, 8'd1, 8'h00, 3'd3, 4'b1000}) begin
            n_fail++; $display("FAIL illegal_op: got %h want %h", o, {8'd1, 4'd0, 8'd1, 8'h00, 3'd3, 4'b1000});
        end
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL illegal_model: got %h want %h", o, e); end
    endtask

    task automatic test_shift_mov();
        logic [34:0] e, o;
        predict(4'd6, 3'd1, 8'h81, 8'h00, e);
        run_op(4'd6, 3'd1, 8'h81, 8'h00, 1'b0, o);
        n_chk++;
        if (o !== e || o[14:0] !== {8'h02, 3'd1, 4'b0010}) begin
            n_fail++; $display("FAIL shl: got %h want %h", o, e);
        end
        predict(4'd7, 3'd2, 8'h01, 8'h00, e);
        run_op(4'd7, 3'd2, 8'h01, 8'h00, 1'b0, o);
        n_chk++;
        if (o !== e || o[14:0] !== {8'h00, 3'd2, 4'b1010}) begin
            n_fail++; $display("FAIL shr: got %h want %h", o, e);
        end
        predict(4'd8, 3'd7, 8'h55, 8'h00, e);
        run_op(4'd8, 3'd7, 8'h55, 8'h00, 1'b0, o);
        n_chk++;
        if (o !== {8'd1, 4'd1, 8'd1, 8'h55, 3'd7, 4'b0000}) begin
            n_fail++; $display("FAIL mov_r7: got %h want %h", o, {8'd1, 4'd1, 8'd1, 8'h55, 3'd7, 4'b0000});
        end
    endtask

    task automatic test_mid_mul_reset();
        int wcnt, busy;
        op = 4'd9; dest = 3'd5; A = 8'd3; B = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL mul_busy: ready %b want 0", ready); end
        #2 rst = 1'b0;
        #1;
        m_d = 8'h00; m_da = 3'd0; m_fl = 4'h0;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        wcnt = 0; busy = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (w) wcnt++;
            if (!ready) busy++;
        end
        n_chk++;
        if (wcnt != 0 || busy != 0 || {D, DA, Z, N_f, C, V} !== {m_d, m_da, m_fl}) begin
            n_fail++;
            $display("FAIL mul_abort: w pulses %0d busy %0d D/DA/fl %h want 0 0 %h",
                     wcnt, busy, {D, DA, Z, N_f, C, V}, {m_d, m_da, m_fl});
        end
    endtask

    task automatic test_random();
        logic [34:0] e, o;
        logic [3:0] ro;
        logic [2:0] rd;
        logic [7:0] ra, rb;
        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom); rd = 3'($urandom);
            ra = 8'($urandom); rb = 8'($urandom);
            if (i % 8 == 0) ra = 8'h00;
            if (i % 8 == 1) ra = 8'h7F;
            if (i % 8 == 2) ra = 8'hFF;
            predict(ro, rd, ra, rb, e);
            run_op(ro, rd, ra, rb, 1'($urandom), o);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h want %h", i, ro, ra, rb, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] e;
        logic [7:0] ra, rb;
        int pulses, bad;
        ra = 8'($urandom); rb = 8'($urandom);
        predict(4'd0, 3'd6, ra, rb, e);
        op = 4'd0; dest = 3'd6; A = ra; B = rb; start = 1'b1;
        pulses = 0; bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (w) begin
                pulses++;
                if ({D, DA, Z, N_f, C, V} !== e[14:0]) bad++;
            end
        end
        start = 1'b0;
        @(negedge clk);
        n_chk++;
        if (pulses != 3 || bad != 0) begin
            n_fail++; $display("FAIL back_to_back: pulses %0d bad %0d want 3 0", pulses, bad);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = 4'd0; dest = 3'd0; A = 8'h00; B = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_add();
        test_sub();
        test_mul();
        test_illegal();
        test_shift_mov();
        test_mid_mul_reset();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
